pdm_tx: RTL and testbench

- Transmit-side counterpart of the microphone PDM receive path.
- Accepts signed PCM samples over a valid/ready handshake and holds each for a programmable number of PDM bit periods (zero-order-hold interpolation).
- Converts them to a 1-bit PDM stream with a first-order sigma-delta modulator, driving its own bit clock.
- Used as a microphone emulator for loopback test of the CIC decimator, and as the PDM driver for an output transducer.

---
 rtl/pdm_pkg.sv | 19 +
 rtl/pdm_tx_if.sv | 12 +
 rtl/pdm_clk_gen.sv | 44 ++++
 rtl/pdm_tx.sv | 122 ++++++++++++
 tb/tb_pdm_tx.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/pdm_pkg.sv
// Shared PDM constants, FSM state encoding and the PCM-to-offset-binary helper.
// Used by both the transmit and receive paths.
package pdm_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned DIV_W  = 32;
  localparam int unsigned HOLD_W = 8;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } tx_state_e;

  // Two's complement to offset binary: -2^(W-1) maps to 0, 0 maps to mid-scale.
  function automatic logic [DATA_W-1:0] to_offset(input logic [DATA_W-1:0] s);
    return {~s[DATA_W-1], s[DATA_W-2:0]};
  endfunction

endpackage

// File: rtl/pdm_tx_if.sv
// PCM sample valid/ready handshake between a producer and the PDM transmitter.
interface pdm_tx_if;
  import pdm_pkg::*;

  logic [DATA_W-1:0] sample_in;
  logic              sample_valid;
  logic              sample_ready;

  modport master (output sample_in, output sample_valid, input  sample_ready);
  modport slave  (input  sample_in, input  sample_valid, output sample_ready);

endinterface

// File: rtl/pdm_clk_gen.sv
// PDM bit-clock generator: programmable half period of clk_div+1 cycles.
// bit_event_c_o marks the clk cycle in which clk_out is about to rise.
module pdm_clk_gen
  import pdm_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [DIV_W-1:0] clk_div_i,
  output logic             clk_out_o,
  output logic             bit_event_c_o
);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             tc_q, tc_d;
  logic             clk_out_q, clk_out_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      tc_q      <= 1'b1;
      clk_out_q <= 1'b1;
    end else begin
      cnt_q     <= cnt_d;
      tc_q      <= tc_d;
      clk_out_q <= clk_out_d;
    end
  end

  // >= makes a lowered clk_div take effect immediately instead of counting to wrap.
  always_comb begin
    cnt_d     = cnt_q + DIV_W'(1);
    tc_d      = 1'b0;
    clk_out_d = clk_out_q;
    if (cnt_q >= clk_div_i) begin
      cnt_d = '0;
      tc_d  = 1'b1;
    end
    if (tc_q) clk_out_d = ~clk_out_q;
  end

  assign clk_out_o     = clk_out_q;
  assign bit_event_c_o = tc_q & ~clk_out_q;

endmodule

// File: rtl/pdm_tx.sv
// PDM transmitter: one-entry sample buffer, zero-order hold of hold_num+1 bits
// per sample and a first-order sigma-delta modulator clocked by the bit clock.
module pdm_tx
  import pdm_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [DIV_W-1:0]  clk_div_i,
  input  logic [HOLD_W-1:0] hold_num_i,
  pdm_tx_if.slave           s_if,
  output logic              clk_out_o,
  output logic              data_out_o,
  output logic              underrun_o
);

  logic bit_event;

  pdm_clk_gen u_clk_gen (
    .clk           (clk),
    .rst           (rst),
    .clk_div_i     (clk_div_i),
    .clk_out_o     (clk_out_o),
    .bit_event_c_o (bit_event)
  );

  tx_state_e         state_q, state_d;
  logic [DATA_W-1:0] cur_q, cur_d;
  logic [DATA_W-1:0] nxt_q, nxt_d;
  logic              nxt_full_q, nxt_full_d;
  logic              ready_q, ready_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic              data_q, data_d;
  logic              und_q, und_d;

  logic              load;
  logic              accept;
  logic [DATA_W-1:0] sel;
  logic [DATA_W:0]   sum;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cur_q      <= '0;
      nxt_q      <= '0;
      nxt_full_q <= 1'b0;
      ready_q    <= 1'b1;
      hold_q     <= '0;
      acc_q      <= '0;
      data_q     <= 1'b0;
      und_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_q      <= cur_d;
      nxt_q      <= nxt_d;
      nxt_full_q <= nxt_full_d;
      ready_q    <= ready_d;
      hold_q     <= hold_d;
      acc_q      <= acc_d;
      data_q     <= data_d;
      und_q      <= und_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cur_d      = cur_q;
    nxt_d      = nxt_q;
    nxt_full_d = nxt_full_q;
    hold_d     = hold_q;
    acc_d      = acc_q;
    data_d     = data_q;
    und_d      = 1'b0;
    load       = 1'b0;
    sel        = cur_q;
    sum        = '0;
    accept     = s_if.sample_valid & ~nxt_full_q;

    // Load slots: first available sample in IDLE, then every hold_num+1 bits in RUN.
    case (state_q)
      IDLE: begin
        if (bit_event && nxt_full_q) begin
          load    = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        if (bit_event && (hold_q == '0)) begin
          if (nxt_full_q) load  = 1'b1;
          else            und_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Load and accept are mutually exclusive: one needs the buffer full, the other empty.
    if (load) begin
      cur_d      = nxt_q;
      sel        = nxt_q;
      nxt_full_d = 1'b0;
    end
    if (accept) begin
      nxt_d      = s_if.sample_in;
      nxt_full_d = 1'b1;
    end

    if (bit_event) begin
      sum    = {1'b0, acc_q} + {1'b0, to_offset(sel)};
      acc_d  = sum[DATA_W-1:0];
      data_d = sum[DATA_W];
      if (state_q == RUN || load)
        hold_d = (hold_q >= hold_num_i) ? '0 : hold_q + HOLD_W'(1);
    end

    ready_d = ~nxt_full_d;
  end

  assign s_if.sample_ready = ready_q;
  assign data_out_o        = data_q;
  assign underrun_o        = und_q;

endmodule

// File: tb/tb_pdm_tx.sv
// Self-checking bench for pdm_tx: directed scenarios plus randomized traffic,
// compared every clk against a bit-event-level reference model.
module tb_pdm_tx;
  import pdm_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] clk_div;
  logic [7:0]  hold_num;
  logic        clk_out, data_out, underrun;

  pdm_tx_if tx_if ();

  pdm_tx dut (
    .clk        (clk),
    .rst        (rst),
    .clk_div_i  (clk_div),
    .hold_num_i (hold_num),
    .s_if       (tx_if),
    .clk_out_o  (clk_out),
    .data_out_o (data_out),
    .underrun_o (underrun)
  );

  always #10 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model state
  int          n_edge;
  int          m_acc;
  logic [15:0] m_cur;
  logic [15:0] m_buf[$];
  bit          m_run;
  int          m_pos;
  bit          m_data, m_und, m_rise, m_accepted;
  int          rise_cnt, und_cnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int period_half();
    return int'(clk_div) + 1;
  endfunction

  // clk_out falls on edge 1 after reset, then toggles every clk_div+1 edges.
  function automatic bit exp_clk(input int n);
    return ((n - 1) / period_half()) % 2 == 1;
  endfunction

  function automatic bit rise_at(input int n);
    return ((n - 1) % period_half() == 0) && exp_clk(n);
  endfunction

  task automatic model_reset();
    n_edge = 0; m_acc = 0; m_cur = '0; m_buf.delete();
    m_run = 0; m_pos = 0; m_data = 0; m_und = 0; m_rise = 0; m_accepted = 0;
    rise_cnt = 0; und_cnt = 0;
  endtask

  // One clk edge of the specified behaviour, using the inputs present before the edge.
  task automatic model_edge();
    bit acc_ok;
    int u, s;
    n_edge++;
    acc_ok     = tx_if.sample_valid && (m_buf.size() == 0);
    m_accepted = acc_ok;
    m_rise     = rise_at(n_edge);
    m_und      = 0;
    if (m_rise) begin
      if (!m_run && m_buf.size() != 0) begin m_run = 1; m_pos = 0; end
      if (m_run && m_pos == 0) begin
        if (m_buf.size() != 0) m_cur = m_buf.pop_front();
        else                   m_und = 1;
      end
      if (m_run) m_pos = (m_pos >= int'(hold_num)) ? 0 : m_pos + 1;
      u      = int'($signed(m_cur)) + 32768;
      s      = m_acc + u;
      m_data = (s >= 65536);
      m_acc  = s % 65536;
      rise_cnt++;
    end
    if (acc_ok) m_buf.push_back(tx_if.sample_in);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    model_edge();
    check("clk_out", 32'(clk_out), 32'(exp_clk(n_edge)));
    check("data_out", 32'(data_out), 32'(m_data));
    check("underrun", 32'(underrun), 32'(m_und));
    check("sample_ready", 32'(tx_if.sample_ready), 32'(m_buf.size() == 0));
    if (underrun === 1'b1) und_cnt++;
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_clk_out"}, 32'(clk_out), 32'd1);
    check({pfx, "_data_out"}, 32'(data_out), 32'd0);
    check({pfx, "_underrun"}, 32'(underrun), 32'd0);
    check({pfx, "_ready"}, 32'(tx_if.sample_ready), 32'd1);
  endtask

  task automatic do_reset(input int unsigned d, input int unsigned h);
    @(negedge clk);
    rst = 1'b1;
    tx_if.sample_valid = 1'b0;
    clk_div  = d;
    hold_num = 8'(h);
    #1;
    check_reset_outputs("rst");
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  // Feed one sample and wait for it to be accepted.
  task automatic push_one(input logic [15:0] v);
    bit done = 0;
    tx_if.sample_valid = 1'b1;
    tx_if.sample_in    = v;
    for (int i = 0; i < 200 && !done; i++) begin
      tick();
      done = m_accepted;
    end
    tx_if.sample_valid = 1'b0;
    if (!done) check("push_timeout", 32'd0, 32'd1);
  endtask

  logic [15:0] a_s, b_s, c_s;
  bit          bits[$];
  int          ones_a, ones_b, nacc, r0, k;
  bit          found;

  initial begin
    tx_if.sample_valid = 1'b0;
    tx_if.sample_in    = '0;
    clk_div  = 32'd2;
    hold_num = 8'd0;
    model_reset();

    // Idle stream at 50 % density, 3/3 bit clock, no underrun
    do_reset(2, 0);
    repeat (60) tick();
    check("idle_underrun_count", 32'(und_cnt), 32'd0);

    // Full-scale negative then positive sample, 64 bits each
    do_reset(0, 63);
    tx_if.sample_valid = 1'b1;
    tx_if.sample_in    = 16'h8000;
    bits.delete();
    for (int i = 0; i < 600 && bits.size() < 128; i++) begin
      tick();
      if (m_rise) bits.push_back(data_out);
      if (m_accepted) begin
        if (tx_if.sample_in == 16'h8000) tx_if.sample_in = 16'h7fff;
        else                             tx_if.sample_valid = 1'b0;
      end
    end
    if (bits.size() < 128) check("fullscale_timeout", 32'd0, 32'd1);
    else begin
      ones_a = 0; ones_b = 0;
      for (int i = 0; i < 64; i++) ones_a += int'(bits[i]);
      for (int i = 64; i < 128; i++) ones_b += int'(bits[i]);
      check("neg_fullscale_ones", 32'(ones_a), 32'd0);
      check("pos_fullscale_ones", 32'(ones_b), 32'd63);
      check("pos_first_bit", 32'(bits[64]), 32'd0);
    end

    // Backpressure: two samples back-to-back, then starve for three slots
    do_reset(1, 3);
    a_s = 16'($urandom); b_s = 16'($urandom);
    tx_if.sample_valid = 1'b1;
    tx_if.sample_in    = a_s;
    nacc = 0;
    for (int i = 0; i < 400 && rise_cnt < 20; i++) begin
      tick();
      if (m_accepted) begin
        nacc++;
        if (nacc == 1) tx_if.sample_in = b_s;
        else           tx_if.sample_valid = 1'b0;
      end
    end
    check("bp_accepts", 32'(nacc), 32'd2);
    check("bp_underrun_count", 32'(und_cnt), 32'd3);

    // Asynchronous reset mid-RUN with the buffer full and clk_out low
    do_reset(1, 3);
    tx_if.sample_valid = 1'b1;
    tx_if.sample_in    = 16'($urandom);
    nacc = 0; found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      tick();
      if (m_accepted) begin
        nacc++;
        tx_if.sample_in = 16'($urandom);
        if (nacc >= 2) tx_if.sample_valid = 1'b0;
      end
      found = (nacc == 2) && m_run && (m_buf.size() == 1) && !exp_clk(n_edge);
    end
    if (!found) check("midrun_setup_timeout", 32'd0, 32'd1);
    #4 rst = 1'b1;
    #1 check_reset_outputs("async");
    @(negedge clk);
    rst = 1'b0;
    tx_if.sample_valid = 1'b0;
    model_reset();
    repeat (16) tick();

    // Sample arrives in the very cycle of an empty load slot
    do_reset(1, 3);
    push_one(16'($urandom));
    found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      if (m_run && m_buf.size() == 0 && m_pos == 0 && rise_at(n_edge + 1)) found = 1;
      else tick();
    end
    if (!found) check("simul_setup_timeout", 32'd0, 32'd1);
    c_s = 16'($urandom);
    tx_if.sample_valid = 1'b1;
    tx_if.sample_in    = c_s;
    tick();
    tx_if.sample_valid = 1'b0;
    check("simul_underrun", 32'(underrun), 32'd1);
    r0 = rise_cnt;
    for (int i = 0; i < 200 && rise_cnt < r0 + 4; i++) tick();
    check("simul_next_slot_loads", 32'(underrun), 32'd0);
    repeat (20) tick();

    // hold_num lowered from 10 to 2 while the hold count sits at 7
    do_reset(0, 10);
    push_one(16'($urandom));
    found = 0;
    for (int i = 0; i < 400 && !found; i++) begin
      tick();
      found = m_run && m_rise && (m_pos == 7);
    end
    if (!found) check("hold_setup_timeout", 32'd0, 32'd1);
    hold_num = 8'd2;
    k = 0; found = 0;
    for (int i = 0; i < 100 && !found; i++) begin
      tick();
      if (m_rise) k++;
      found = (underrun === 1'b1);
    end
    check("hold_shrink_wrap", 32'(k), 32'd2);
    repeat (30) tick();

    // Randomized traffic
    for (int r = 0; r < 3; r++) begin
      do_reset($urandom_range(0, 3), $urandom_range(0, 5));
      for (int i = 0; i < 1500; i++) begin
        tick();
        if (m_accepted || !tx_if.sample_valid) begin
          tx_if.sample_valid = 1'($urandom_range(0, 2) != 0);
          tx_if.sample_in    = 16'($urandom);
        end
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
